// File: rtl/ir_pkg.sv
// Shared IR link definitions: receiver FSM state encoding and the default frame
// timing, so the transmitter and receiver agree on one set of numbers.
package ir_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t SYNC  = 2'd1;
  localparam state_t SPACE = 2'd2;
  localparam state_t BIT   = 2'd3;

  // Nominal level lengths in clk_in cycles at 100 MHz
  localparam int SBD            = 240_000;
  localparam int BSD            = 60_000;
  localparam int BBD0           = 60_000;
  localparam int BBD1           = 120_000;
  localparam int MARGIN         = 20_000;
  localparam int MESSAGE_LENGTH = 30;

endpackage

// File: rtl/ir_receiver_sync_edge.sv
// Two-flop synchronizer for the asynchronous IR envelope, plus single-cycle
// rise/fall strobes derived from the synchronized level and its previous copy.
module sync_edge (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic async_sig,
  output logic rise,
  output logic fall
);

  logic meta;
  logic stable;
  logic stable_d;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      meta     <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
    end else begin
      meta     <= async_sig;
      stable   <= meta;
      stable_d <= stable;
    end
  end

  assign rise = stable & ~stable_d;
  assign fall = ~stable & stable_d;

endmodule

// File: rtl/ir_receiver.sv
// Pulse-width IR frame decoder: measures every high/low level, classifies it
// against the timing windows and emits the payload with a one-cycle valid strobe.
module ir_receiver #(
  parameter int SBD            = ir_pkg::SBD,
  parameter int BSD            = ir_pkg::BSD,
  parameter int BBD0           = ir_pkg::BBD0,
  parameter int BBD1           = ir_pkg::BBD1,
  parameter int MARGIN         = ir_pkg::MARGIN,
  parameter int MESSAGE_LENGTH = ir_pkg::MESSAGE_LENGTH
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      signal_in,
  output logic [MESSAGE_LENGTH-1:0] data_out,
  output logic                      data_valid_out,
  output logic                      error_out,
  output logic                      busy_out
);

  import ir_pkg::*;

  localparam int BCW = $clog2(MESSAGE_LENGTH + 1);
  localparam logic [31:0] SYNC_MAX  = 32'(SBD + MARGIN);
  localparam logic [31:0] SPACE_MAX = 32'(BSD + MARGIN);
  localparam logic [31:0] BIT_MAX   = 32'(BBD1 + MARGIN);

  if (!((BBD0 + MARGIN < BBD1 - MARGIN) && (MARGIN < BSD) && (MESSAGE_LENGTH >= 2)))
  begin : g_bad_params
    $error("ir_receiver: overlapping bit windows, MARGIN >= BSD or MESSAGE_LENGTH < 2");
  end

  logic                      rise;
  logic                      fall;
  logic [31:0]               level_count;
  state_t                    state;
  logic [BCW-1:0]            bit_cnt;
  logic [MESSAGE_LENGTH-1:0] shift_reg;
  logic                      bit_is_one;
  logic                      bit_ok;
  logic                      last_bit;

  // 33-bit compare so a saturated counter cannot wrap into the window
  function automatic logic in_window(input logic [31:0] cnt, input int nominal);
    logic [32:0] c;
    c = {1'b0, cnt};
    return (c + 33'(MARGIN) >= 33'(nominal)) && (c <= 33'(nominal) + 33'(MARGIN));
  endfunction

  sync_edge u_sync_edge (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .async_sig (signal_in),
    .rise      (rise),
    .fall      (fall)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      level_count <= '0;
    end else if (rise || fall) begin
      level_count <= '0;
    end else if (level_count != '1) begin
      level_count <= level_count + 32'd1;
    end
  end

  assign bit_is_one = in_window(level_count, BBD1);
  assign bit_ok     = bit_is_one || in_window(level_count, BBD0);
  assign last_bit   = (bit_cnt == BCW'(MESSAGE_LENGTH - 1));
  assign busy_out   = (state != IDLE);

  // Any failed window or timeout aborts to IDLE; data_out only moves on success
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state          <= IDLE;
      bit_cnt        <= '0;
      shift_reg      <= '0;
      data_out       <= '0;
      data_valid_out <= 1'b0;
      error_out      <= 1'b0;
    end else begin
      data_valid_out <= 1'b0;
      error_out      <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) state <= SYNC;
        end
        SYNC: begin
          if (fall && in_window(level_count, SBD)) begin
            state   <= SPACE;
            bit_cnt <= '0;
          end else if (fall || level_count > SYNC_MAX) begin
            state     <= IDLE;
            error_out <= 1'b1;
          end
        end
        SPACE: begin
          if (rise && in_window(level_count, BSD)) begin
            state <= BIT;
          end else if (rise || level_count > SPACE_MAX) begin
            state     <= IDLE;
            error_out <= 1'b1;
          end
        end
        BIT: begin
          if (fall && bit_ok) begin
            shift_reg <= {shift_reg[MESSAGE_LENGTH-2:0], bit_is_one};
            bit_cnt   <= bit_cnt + BCW'(1);
            if (last_bit) begin
              data_out       <= {shift_reg[MESSAGE_LENGTH-2:0], bit_is_one};
              data_valid_out <= 1'b1;
              state          <= IDLE;
            end else begin
              state <= SPACE;
            end
          end else if (fall || level_count > BIT_MAX) begin
            state     <= IDLE;
            error_out <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ir_receiver.sv
// Directed bench for ir_receiver with shortened timing; a level held for N+1
// clock cycles is measured by the receiver as a count of N.
module tb_ir_receiver;

  localparam int SBD    = 240;
  localparam int BSD    = 60;
  localparam int BBD0   = 60;
  localparam int BBD1   = 120;
  localparam int MARGIN = 20;
  localparam int ML     = 8;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic          signal_in;
  logic [ML-1:0] data_out;
  logic          data_valid_out;
  logic          error_out;
  logic          busy_out;

  int errors = 0;
  int checks = 0;
  int cycle = 0;
  int valid_cnt = 0;
  int error_cnt = 0;
  int valid_cycle = 0;
  int error_cycle = 0;
  int overlap_cnt = 0;
  int last_fall_cycle = 0;
  logic [ML-1:0] last_valid_data = '0;
  logic [ML-1:0] prev_valid_data = '0;

  ir_receiver #(
    .SBD(SBD), .BSD(BSD), .BBD0(BBD0), .BBD1(BBD1),
    .MARGIN(MARGIN), .MESSAGE_LENGTH(ML)
  ) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .signal_in      (signal_in),
    .data_out       (data_out),
    .data_valid_out (data_valid_out),
    .error_out      (error_out),
    .busy_out       (busy_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cycle <= cycle + 1;

  // Pulse monitor sampled on the falling edge, away from the active edge
  always @(negedge clk_in) begin
    if (rst_n_in === 1'b1) begin
      if (data_valid_out === 1'b1) begin
        valid_cnt       <= valid_cnt + 1;
        valid_cycle     <= cycle;
        prev_valid_data <= last_valid_data;
        last_valid_data <= data_out;
      end
      if (error_out === 1'b1) begin
        error_cnt   <= error_cnt + 1;
        error_cycle <= cycle;
      end
      if (data_valid_out === 1'b1 && error_out === 1'b1) overlap_cnt <= overlap_cnt + 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic hold(input logic v, input int n);
    signal_in = v;
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    hold(1'b0, BSD + 1);
    hold(1'b1, b ? BBD1 + 1 : BBD0 + 1);
  endtask

  task automatic send_frame(input logic [ML-1:0] w, input int sync_len, input int gap);
    hold(1'b1, sync_len);
    for (int i = ML - 1; i >= 0; i--) send_bit(w[i]);
    last_fall_cycle = cycle;
    hold(1'b0, gap);
  endtask

  task automatic test_reset;
    rst_n_in  = 1'b0;
    signal_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h expected 00", data_out); end
    checks++; if (data_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", data_valid_out); end
    checks++; if (error_out !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", error_out); end
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_out); end
    rst_n_in = 1'b1;
    hold(1'b0, 5);
  endtask

  task automatic test_clean_frame;
    int v0, e0;
    v0 = valid_cnt;
    e0 = error_cnt;
    send_frame(8'hA5, SBD + 1, 10);
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL clean_valid_count: got %0d expected 1", valid_cnt - v0); end
    checks++; if (last_valid_data !== 8'hA5) begin errors++; $display("FAIL clean_data: got %h expected a5", last_valid_data); end
    checks++; if (valid_cycle - last_fall_cycle !== 3) begin errors++; $display("FAIL clean_latency: got %0d expected 3", valid_cycle - last_fall_cycle); end
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL clean_busy_after: got %b expected 0", busy_out); end
    checks++; if (error_cnt - e0 !== 0) begin errors++; $display("FAIL clean_no_error: got %0d expected 0", error_cnt - e0); end
  endtask

  task automatic test_window_edges;
    int v0, e0;
    int rej[2] = '{SBD - MARGIN, SBD + MARGIN + 2};
    v0 = valid_cnt;
    send_frame(8'h5A, SBD - MARGIN + 1, 10);
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL win_low_valid: got %0d expected 1", valid_cnt - v0); end
    checks++; if (last_valid_data !== 8'h5A) begin errors++; $display("FAIL win_low_data: got %h expected 5a", last_valid_data); end
    v0 = valid_cnt;
    send_frame(8'hC3, SBD + MARGIN + 1, 10);
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL win_high_valid: got %0d expected 1", valid_cnt - v0); end
    checks++; if (last_valid_data !== 8'hC3) begin errors++; $display("FAIL win_high_data: got %h expected c3", last_valid_data); end
    for (int k = 0; k < 2; k++) begin
      v0 = valid_cnt;
      e0 = error_cnt;
      hold(1'b1, rej[k]);
      hold(1'b0, 30);
      checks++; if (error_cnt - e0 !== 1) begin errors++; $display("FAIL win_reject_error len=%0d: got %0d expected 1", rej[k], error_cnt - e0); end
      checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL win_reject_valid len=%0d: got %0d expected 0", rej[k], valid_cnt - v0); end
      checks++; if (data_out !== 8'hC3) begin errors++; $display("FAIL win_reject_data len=%0d: got %h expected c3", rej[k], data_out); end
    end
  endtask

  task automatic test_bad_bit;
    int v0, e0;
    v0 = valid_cnt;
    e0 = error_cnt;
    hold(1'b1, SBD + 1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    hold(1'b0, BSD + 1);
    hold(1'b1, 91);
    hold(1'b0, 30);
    checks++; if (error_cnt - e0 !== 1) begin errors++; $display("FAIL badbit_error: got %0d expected 1", error_cnt - e0); end
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL badbit_valid: got %0d expected 0", valid_cnt - v0); end
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL badbit_idle: got busy %b expected 0", busy_out); end
    v0 = valid_cnt;
    send_frame(8'h3C, SBD + 1, 10);
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL recover_valid: got %0d expected 1", valid_cnt - v0); end
    checks++; if (last_valid_data !== 8'h3C) begin errors++; $display("FAIL recover_data: got %h expected 3c", last_valid_data); end
  endtask

  task automatic test_timeout;
    int v0, e0, rise_cycle, waited;
    v0 = valid_cnt;
    e0 = error_cnt;
    signal_in  = 1'b1;
    rise_cycle = cycle;
    waited     = 0;
    while (error_cnt == e0 && waited < 400) begin
      @(posedge clk_in);
      #1;
      waited++;
    end
    checks++;
    if (error_cnt == e0) begin
      errors++;
      $display("FAIL timeout_wait: got no error_out in 400 cycles expected one");
    end else if (error_cycle - rise_cycle !== 265) begin
      errors++;
      $display("FAIL timeout_latency: got %0d expected 265 cycles after drive", error_cycle - rise_cycle);
    end
    hold(1'b1, 20);
    hold(1'b0, 30);
    checks++; if (error_cnt - e0 !== 1) begin errors++; $display("FAIL timeout_error_count: got %0d expected 1", error_cnt - e0); end
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL timeout_valid: got %0d expected 0", valid_cnt - v0); end
  endtask

  task automatic test_reset_mid_frame;
    int v0, e0;
    e0 = error_cnt;
    hold(1'b1, SBD + 1);
    send_bit(1'b1);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    hold(1'b0, BSD + 1);
    hold(1'b1, 30);
    rst_n_in = 1'b0;
    #1;
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL midreset_data: got %h expected 00", data_out); end
    checks++; if (data_valid_out !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b expected 0", data_valid_out); end
    checks++; if (error_out !== 1'b0) begin errors++; $display("FAIL midreset_error: got %b expected 0", error_out); end
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy_out); end
    signal_in = 1'b0;
    repeat (5) @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    hold(1'b0, 20);
    checks++; if (error_cnt - e0 !== 0) begin errors++; $display("FAIL midreset_no_error: got %0d expected 0", error_cnt - e0); end
    v0 = valid_cnt;
    send_frame(8'h81, SBD + 1, 10);
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL midreset_recover_valid: got %0d expected 1", valid_cnt - v0); end
    checks++; if (last_valid_data !== 8'h81) begin errors++; $display("FAIL midreset_recover_data: got %h expected 81", last_valid_data); end
  endtask

  task automatic test_back_to_back;
    int v0;
    v0 = valid_cnt;
    send_frame(8'hFF, SBD + 1, 10);
    send_frame(8'h00, SBD + 1, 10);
    checks++; if (valid_cnt - v0 !== 2) begin errors++; $display("FAIL b2b_valid_count: got %0d expected 2", valid_cnt - v0); end
    checks++; if (prev_valid_data !== 8'hFF) begin errors++; $display("FAIL b2b_first_data: got %h expected ff", prev_valid_data); end
    checks++; if (last_valid_data !== 8'h00) begin errors++; $display("FAIL b2b_second_data: got %h expected 00", last_valid_data); end
    checks++; if (overlap_cnt !== 0) begin errors++; $display("FAIL valid_error_overlap: got %0d expected 0", overlap_cnt); end
  endtask

  initial begin
    $display("[TB] ir_receiver directed test start");
    test_reset;
    test_clean_frame;
    test_window_edges;
    test_bad_bit;
    test_timeout;
    test_reset_mid_frame;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
